tape_player: RTL



---
 rtl/tape_player.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tape_player.sv
// Cassette playback source: captures a raw tape image from the OSD download stream and
// replays it on `ear` using Lynx bit encoding. Optional macro TAPE_MOTOR_GATE_EN adds `motor`.
module tape_player #(
    parameter int unsigned AW         = 16,
    parameter logic [7:0]  TAPE_INDEX = 8'h01,
    parameter logic [15:0] HALF0      = 16'd833,
    parameter logic [15:0] HALF1      = 16'd1666,
    parameter logic [11:0] LEADER     = 12'd768,
    parameter logic [23:0] GAP        = 24'd400000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          play,
    input  logic          stop,
`ifdef TAPE_MOTOR_GATE_EN
    input  logic          motor,
`endif
    output logic          ear,
    output logic          busy,
    output logic [AW-1:0] pos
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SYNC, S_FETCH, S_BITS, S_GAP} state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_rd_data;
    logic [LW-1:0] r_len;
    logic          r_dl_prev, r_play_prev;

    state_t        r_state, w_state_nxt;
    logic          r_ear, w_ear_nxt;
    logic          r_busy;
    logic [AW-1:0] r_pos, w_pos_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [11:0]   r_bitcnt, w_bitcnt_nxt;
    logic [15:0]   r_cnt, w_cnt_nxt;
    logic          r_low, w_low_nxt;
    logic          r_armed, w_armed_nxt;
    logic [23:0]   r_gap_cnt, w_gap_nxt;
    logic          r_fetch_ph, w_fetch_ph_nxt;
    logic          w_bit_done;

    logic          w_dl_match, w_dl_start, w_in_range, w_wr, w_play_edge, w_tick;
    logic [LW-1:0] w_addr1, w_len_base;
    logic [15:0]   w_half;

    assign w_dl_match  = ioctl_download && (ioctl_index == TAPE_INDEX);
    assign w_dl_start  = w_dl_match && !r_dl_prev;
    assign w_in_range  = (ioctl_addr[24:AW] == '0);
    assign w_wr        = w_dl_match && ioctl_wr && w_in_range;
    assign w_addr1     = LW'(ioctl_addr[AW-1:0]) + LW'(1);
    assign w_len_base  = w_dl_start ? '0 : r_len;
    assign w_play_edge = play && !r_play_prev;
`ifdef TAPE_MOTOR_GATE_EN
    assign w_tick      = ce && motor;
`else
    assign w_tick      = ce;
`endif

    always_comb begin
        w_half = HALF0;
        if (r_state == S_SYNC)                    w_half = HALF1;
        else if (r_state == S_BITS && r_shift[7]) w_half = HALF1;
    end

    // Image buffer: separate write port, registered read of buf[pos]
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[ioctl_addr[AW-1:0]] <= ioctl_data;
        r_rd_data <= r_mem[r_pos];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len       <= '0;
            r_dl_prev   <= 1'b0;
            r_play_prev <= 1'b0;
        end else begin
            r_len       <= (w_wr && (w_addr1 > w_len_base)) ? w_addr1 : w_len_base;
            r_dl_prev   <= w_dl_match;
            r_play_prev <= play;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ear      <= 1'b0;
            r_busy     <= 1'b0;
            r_pos      <= '0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_cnt      <= '0;
            r_low      <= 1'b0;
            r_armed    <= 1'b0;
            r_gap_cnt  <= '0;
            r_fetch_ph <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ear      <= w_ear_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_pos      <= w_pos_nxt;
            r_shift    <= w_shift_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_low      <= w_low_nxt;
            r_armed    <= w_armed_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_fetch_ph <= w_fetch_ph_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ear_nxt      = r_ear;
        w_pos_nxt      = r_pos;
        w_shift_nxt    = r_shift;
        w_bitcnt_nxt   = r_bitcnt;
        w_cnt_nxt      = r_cnt;
        w_low_nxt      = r_low;
        w_armed_nxt    = r_armed;
        w_gap_nxt      = r_gap_cnt;
        w_fetch_ph_nxt = r_fetch_ph;
        w_bit_done     = 1'b0;

        // Bit generator: a bit finishes one tick early so the next rise lands on the nominal tick
        // and FETCH fits between ticks (assumes H >= 2)
        if ((r_state == S_LEAD || r_state == S_SYNC || r_state == S_BITS) && w_tick) begin
            if (!r_armed) begin
                w_ear_nxt   = 1'b1;
                w_cnt_nxt   = w_half - 16'd1;
                w_low_nxt   = 1'b0;
                w_armed_nxt = 1'b1;
            end else if (r_cnt != 16'd0) begin
                w_cnt_nxt = r_cnt - 16'd1;
            end else if (!r_low) begin
                w_ear_nxt = 1'b0;
                w_low_nxt = 1'b1;
                w_cnt_nxt = w_half - 16'd2;
            end else begin
                w_armed_nxt = 1'b0;
                w_bit_done  = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                w_ear_nxt = 1'b0;
                if (w_play_edge && (r_len != '0) && !w_dl_match) begin
                    w_state_nxt  = S_LEAD;
                    w_pos_nxt    = '0;
                    w_bitcnt_nxt = LEADER;
                    w_armed_nxt  = 1'b0;
                end
            end
            S_LEAD: begin
                if (w_bit_done) begin
                    if (r_bitcnt <= 12'd1) w_state_nxt = S_SYNC;
                    else                   w_bitcnt_nxt = r_bitcnt - 12'd1;
                end
            end
            S_SYNC: begin
                if (w_bit_done) begin
                    w_state_nxt    = S_FETCH;
                    w_fetch_ph_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                if (!r_fetch_ph) begin
                    w_fetch_ph_nxt = 1'b1;
                end else begin
                    w_fetch_ph_nxt = 1'b0;
                    w_shift_nxt    = r_rd_data;
                    w_bitcnt_nxt   = 12'd8;
                    w_state_nxt    = S_BITS;
                end
            end
            S_BITS: begin
                if (w_bit_done) begin
                    w_shift_nxt = {r_shift[6:0], 1'b0};
                    if (r_bitcnt > 12'd1) begin
                        w_bitcnt_nxt = r_bitcnt - 12'd1;
                    end else if ((LW'(r_pos) + LW'(1)) == r_len) begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = GAP;
                    end else begin
                        w_pos_nxt      = r_pos + AW'(1);
                        w_state_nxt    = S_FETCH;
                        w_fetch_ph_nxt = 1'b0;
                    end
                end
            end
            S_GAP: begin
                w_ear_nxt = 1'b0;
                if (w_tick) begin
                    if (r_gap_cnt <= 24'd1) w_state_nxt = S_IDLE;
                    else                    w_gap_nxt   = r_gap_cnt - 24'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Stop and a fresh download abort playback from any state
        if (stop || w_dl_start) begin
            w_state_nxt    = S_IDLE;
            w_ear_nxt      = 1'b0;
            w_armed_nxt    = 1'b0;
            w_low_nxt      = 1'b0;
            w_fetch_ph_nxt = 1'b0;
        end
    end

    assign ear  = r_ear;
    assign busy = r_busy;
    assign pos  = r_pos;

endmodule
